// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
// The FSM encoding and the UART frame shape live here.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Flat bit index into a word for a given byte lane and data bit.
  function automatic int unsigned bit_pos(input int unsigned byte_idx,
                                          input int unsigned bit_idx);
    return byte_idx * UART_DATA_BITS + bit_idx;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// A clear forces the count back to zero so every state entry starts a fresh bit.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_baud_cnt;

  assign o_tick_c = (r_baud_cnt == CNT_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baud_cnt <= '0;
    end else if (i_clear || o_tick_c) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_drain_tx.sv
// Drains words from the rd_clk-side FIFO and sends each one as back-to-back
// 8N1 UART frames, low byte first. All outputs come straight from flops.
module uart_fifo_drain_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_LEN    = 16,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic                rd_clk,
  input  logic                reset,
  input  logic                tx_enable,
  input  logic                fifo_empty,
  input  logic [DATA_LEN-1:0] fifo_data,
  output logic                fifo_read_en,
  output logic                uart_tx,
  output logic                busy,
  output logic                word_done
);

  localparam int unsigned CLKS_PER_BIT   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned BYTES_PER_WORD = DATA_LEN / 8;
  localparam int unsigned BYTE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned POS_W  = $clog2(DATA_LEN);

  localparam logic [2:0]        LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]        LAST_STOP_BIT = 3'(UART_STOP_BITS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE     = BYTE_W'(BYTES_PER_WORD - 1);

  tx_state_t           r_state;
  tx_state_t           w_state_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [BYTE_W-1:0]   r_byte_idx;
  logic [BYTE_W-1:0]   w_byte_idx_nxt;
  logic [DATA_LEN-1:0] r_word_reg;
  logic [DATA_LEN-1:0] w_word_nxt;
  logic [POS_W-1:0]    w_pos_nxt;
  logic                w_tick;
  logic                w_clear;
  logic                w_tx_nxt;
  logic                w_word_done_nxt;

  logic                r_uart_tx;
  logic                r_fifo_read_en;
  logic                r_busy;
  logic                r_word_done;

  // Every state change restarts the bit period from zero.
  assign w_clear = (w_state_nxt != r_state);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk   (rd_clk),
    .i_rst   (reset),
    .i_clear (w_clear),
    .o_tick_c(w_tick)
  );

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_word_reg <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word_reg <= w_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_idx_nxt   = r_bit_idx;
    w_byte_idx_nxt  = r_byte_idx;
    w_word_nxt      = r_word_reg;
    w_word_done_nxt = 1'b0;
    w_tx_nxt        = 1'b1;
    w_pos_nxt       = '0;

    case (r_state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          w_state_nxt = POP;
        end
      end
      POP: begin
        w_state_nxt = LATCH;
      end
      LATCH: begin
        w_word_nxt     = fifo_data;
        w_byte_idx_nxt = '0;
        w_state_nxt    = START;
      end
      START: begin
        if (w_tick) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_DATA_BIT) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit_idx != LAST_STOP_BIT) begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end else if (r_byte_idx == LAST_BYTE) begin
            w_bit_idx_nxt   = '0;
            w_word_done_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else begin
            w_bit_idx_nxt  = '0;
            w_byte_idx_nxt = r_byte_idx + BYTE_W'(1);
            w_state_nxt    = START;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Line level is decoded from the next state so uart_tx lines up with r_state.
    w_pos_nxt = POS_W'(bit_pos(32'(w_byte_idx_nxt), 32'(w_bit_idx_nxt)));
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_word_reg[w_pos_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      r_uart_tx      <= 1'b1;
      r_fifo_read_en <= 1'b0;
      r_busy         <= 1'b0;
      r_word_done    <= 1'b0;
    end else begin
      r_uart_tx      <= w_tx_nxt;
      r_fifo_read_en <= (w_state_nxt == POP);
      r_busy         <= (w_state_nxt != IDLE);
      r_word_done    <= w_word_done_nxt;
    end
  end

  assign uart_tx      = r_uart_tx;
  assign fifo_read_en = r_fifo_read_en;
  assign busy         = r_busy;
  assign word_done    = r_word_done;

endmodule

// File: tb/tb_uart_fifo_drain_tx.sv
// Bench for uart_fifo_drain_tx: a small FIFO model feeds the DUT, a line
// receiver rebuilds each word and a scoreboard compares it with what was queued.
module tb_uart_fifo_drain_tx;

  localparam int unsigned DATA_LEN = 16;
  localparam int unsigned CPB      = 4;
  localparam int unsigned NSAMP    = 2 * 10 * CPB;

  logic                rd_clk = 1'b0;
  logic                reset;
  logic                tx_enable;
  logic                fifo_empty = 1'b1;
  logic [DATA_LEN-1:0] fifo_data  = '0;
  logic                fifo_read_en;
  logic                uart_tx;
  logic                busy;
  logic                word_done;

  logic [DATA_LEN-1:0] fifo_q[$];
  logic [DATA_LEN-1:0] exp_q[$];

  int cyc        = 0;
  int rd_cnt     = 0;
  int rd_run     = 0;
  int rd_run_max = 0;
  int wd_cnt     = 0;
  int n_checks   = 0;
  int n_errors   = 0;

  uart_fifo_drain_tx #(
    .DATA_LEN   (DATA_LEN),
    .CLK_FREQ_HZ(8),
    .BAUD_RATE  (2)
  ) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .tx_enable   (tx_enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .word_done   (word_done)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model with registered data_out, plus pop / word_done bookkeeping.
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en) begin
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      rd_cnt <= rd_cnt + 1;
      rd_run <= rd_run + 1;
      if (rd_run + 1 > rd_run_max) rd_run_max <= rd_run + 1;
    end else begin
      rd_run <= 0;
    end
    if (word_done) wd_cnt <= wd_cnt + 1;
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_LEN-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Receive one word starting from the current negedge; optionally drop tx_enable mid-frame.
  task automatic rx_word(input int drop_at, output logic [DATA_LEN-1:0] word,
                         output int start_cyc, output int done_cyc);
    logic [NSAMP-1:0] smp;
    int waited;
    logic wd_seen;
    logic unstable;
    word      = '0;
    waited    = 0;
    wd_seen   = 1'b0;
    unstable  = 1'b0;
    start_cyc = cyc;
    done_cyc  = cyc;
    while (uart_tx !== 1'b0 && waited < 300) begin
      @(negedge rd_clk);
      waited++;
    end
    if (waited >= 300) begin
      check("rx_start_timeout", 32'(waited), 32'd0);
      return;
    end
    start_cyc = cyc;
    for (int s = 0; s < int'(NSAMP); s++) begin
      smp[s]  = uart_tx;
      wd_seen = wd_seen | word_done;
      if (s == drop_at) tx_enable = 1'b0;
      @(negedge rd_clk);
    end
    done_cyc = cyc;
    check("word_done_at_end", 32'(word_done), 32'd1);
    check("word_done_early", 32'(wd_seen), 32'd0);
    for (int p = 0; p < 20; p++) begin
      for (int k = 1; k < int'(CPB); k++)
        if (smp[p*CPB+k] !== smp[p*CPB]) unstable = 1'b1;
      if (p % 10 == 0)      check("start_bit", 32'(smp[p*CPB]), 32'd0);
      else if (p % 10 == 9) check("stop_bit", 32'(smp[p*CPB]), 32'd1);
      else                  word[(p/10)*8 + (p%10) - 1] = smp[p*CPB];
    end
    check("bit_stable", 32'(unstable), 32'd0);
  endtask

  task automatic rx_and_score(input int drop_at, output int sc, output int dc);
    logic [DATA_LEN-1:0] w;
    rx_word(drop_at, w, sc, dc);
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else                   check("sb_word", 32'(w), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   sc0, dc0, sc1, dc1, rd0;
    logic tx_min, rd_max, busy_max;

    // Reset held with a non-empty FIFO and tx_enable high.
    reset     = 1'b1;
    tx_enable = 1'b1;
    push_word(16'hA55A);
    tx_min = 1'b1; rd_max = 1'b0; busy_max = 1'b0;
    repeat (10) begin
      @(negedge rd_clk);
      tx_min   = tx_min & uart_tx;
      rd_max   = rd_max | fifo_read_en;
      busy_max = busy_max | busy;
    end
    check("rst_uart_tx", 32'(tx_min), 32'd1);
    check("rst_read_en", 32'(rd_max), 32'd0);
    check("rst_busy", 32'(busy_max), 32'd0);
    check("rst_word_done", 32'(word_done), 32'd0);

    // Released with tx_enable low: nothing may be popped.
    tx_enable = 1'b0;
    reset     = 1'b0;
    rd0 = rd_cnt;
    repeat (20) @(negedge rd_clk);
    check("no_pop_disabled", 32'(rd_cnt - rd0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single word 0xA55A.
    tx_enable = 1'b1;
    rd0 = rd_cnt;
    rx_and_score(-1, sc0, dc0);
    check("pop_count_single", 32'(rd_cnt - rd0), 32'd1);

    // Empty FIFO with tx_enable high for 100 cycles.
    rd0 = rd_cnt;
    tx_min = 1'b1; busy_max = 1'b0;
    repeat (100) begin
      @(negedge rd_clk);
      tx_min   = tx_min & uart_tx;
      busy_max = busy_max | busy;
    end
    check("empty_no_pop", 32'(rd_cnt - rd0), 32'd0);
    check("empty_tx_high", 32'(tx_min), 32'd1);
    check("empty_busy", 32'(busy_max), 32'd0);

    // Two words back to back.
    rd0 = rd_cnt;
    sc0 = wd_cnt;
    push_word(16'h0001);
    push_word(16'h8000);
    begin
      int wd0;
      wd0 = sc0;
      rx_and_score(-1, sc0, dc0);
      rx_and_score(-1, sc1, dc1);
      check("inter_word_gap", 32'(sc1 - dc0), 32'd3);
      repeat (20) @(negedge rd_clk);
      check("b2b_pops", 32'(rd_cnt - rd0), 32'd2);
      check("b2b_word_done", 32'(wd_cnt - wd0), 32'd2);
    end

    // tx_enable dropped during byte 0 data bits with three words queued.
    push_word(16'h1234);
    push_word(16'h5678);
    push_word(16'h9ABC);
    rd0 = rd_cnt;
    rx_and_score(CPB + 4, sc0, dc0);
    check("drop_busy_after_done", 32'(busy), 32'd0);
    tx_min = 1'b1;
    repeat (30) begin
      @(negedge rd_clk);
      tx_min = tx_min & uart_tx;
    end
    check("drop_pops", 32'(rd_cnt - rd0), 32'd1);
    check("drop_line_idle", 32'(tx_min), 32'd1);
    check("drop_busy_idle", 32'(busy), 32'd0);

    // Reset mid data bit while the line is low; 0x5678 starts with a 0 data bit.
    tx_enable = 1'b1;
    rd0 = rd_cnt;
    begin
      int waited;
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 300) begin
        @(negedge rd_clk);
        waited++;
      end
      check("rst_test_start", 32'(waited < 300), 32'd1);
    end
    repeat (CPB + 1) @(negedge rd_clk);
    check("pre_reset_tx_low", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(uart_tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge rd_clk);
    check("rst_hold_read_en", 32'(fifo_read_en), 32'd0);
    reset = 1'b0;
    rx_and_score(-1, sc0, dc0);
    check("post_rst_pops", 32'(rd_cnt - rd0), 32'd2);
    check("pulse_width", 32'(rd_run_max), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
